// File: rtl/sample_fifo.sv
// Parametrised show-ahead sample FIFO between the S/PDIF decoder and the I2S serialiser.
// Registered occupancy counter drives all status flags; sticky overflow/underflow; synchronous flush.
module sample_fifo #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = (2 ** DEPTH_LOG2) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  write,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read,
  output logic [WIDTH-1:0]      read_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0]         LVL_ONE   = LW'(1);
  localparam logic [LW-1:0]         LVL_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0]         LVL_AF    = LW'(AF_LEVEL);
  localparam logic [LW-1:0]         LVL_AE    = LW'(AE_LEVEL);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_w, empty_w;
  logic                  wr_acc, rd_acc;

  assign full_w  = (level_q == LVL_DEPTH);
  assign empty_w = (level_q == '0);

  // A full FIFO still accepts a write when a read frees the head slot on the same edge.
  always_comb begin
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      wr_acc = write && (!full_w || read);
      rd_acc = read && !empty_w;
      if (write && full_w && !read) overflow_d  = 1'b1;
      if (read && empty_w)          underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; contents are only meaningful while level > 0.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= write_data;
  end

  assign read_data    = mem_q[rd_ptr_q];
  assign level        = level_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo (WIDTH=16, DEPTH=16).
module tb_sample_fifo;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        write;
  logic [15:0] write_data;
  logic        read;
  logic [15:0] read_data;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  sample_fifo #(
    .WIDTH     (16),
    .DEPTH_LOG2(4),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .write       (write),
    .write_data  (write_data),
    .read        (read),
    .read_data   (read_data),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_ae"},    32'(almost_empty), 32'd1);
    chk({tag, "_af"},    32'(almost_full),  32'd0);
    chk({tag, "_ovf"},   32'(overflow),  32'd0);
    chk({tag, "_unf"},   32'(underflow), 32'd0);
  endtask

  initial begin
    int unsigned cnt;
    resetn     = 1'b0;
    flush      = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    write_data = '0;

    // Reset held with write pulses active
    #2;
    for (int i = 0; i < 3; i++) begin
      write      = 1'b1;
      write_data = 16'(16'hA0 + i);
      step();
      chk_idle_reset("rst_hold");
    end
    write  = 1'b0;
    resetn = 1'b1;
    step();
    chk_idle_reset("rst_rel");

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) begin
      write      = 1'b1;
      write_data = 16'(i);
      step();
      chk("fill_level", 32'(level), 32'(i));
      chk("fill_full",  32'(full),  32'(i == 16));
      chk("fill_af",    32'(almost_full),  32'(i >= 14));
      chk("fill_ae",    32'(almost_empty), 32'(i <= 2));
      chk("fill_head",  32'(read_data), 32'h1);
    end
    write_data = 16'h0011;
    step();
    chk("drop_ovf",   32'(overflow),  32'd1);
    chk("drop_level", 32'(level),     32'd16);
    chk("drop_head",  32'(read_data), 32'h1);
    write = 1'b0;

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(read_data), 32'(i));
      read = 1'b1;
      step();
      chk("drain_level", 32'(level), 32'(16 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_unf0",  32'(underflow), 32'd0);
    step();
    read = 1'b0;
    chk("under_unf",   32'(underflow), 32'd1);
    chk("under_level", 32'(level), 32'd0);
    chk("under_ovf",   32'(overflow), 32'd1);

    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_idle_reset("flush1");

    // Wrap-around: alternate write/read past the pointer wrap
    cnt = 32'h300;
    for (int i = 0; i < 40; i++) begin
      if ((i % 2) == 0) begin
        write      = 1'b1;
        read       = 1'b0;
        write_data = 16'(cnt);
        step();
        chk("wrap_data",  32'(read_data), 32'(16'(cnt)));
        chk("wrap_level", 32'(level), 32'd1);
        cnt++;
      end else begin
        write = 1'b0;
        read  = 1'b1;
        step();
        chk("wrap_level", 32'(level), 32'd0);
      end
    end
    read = 1'b0;
    chk("wrap_ovf", 32'(overflow),  32'd0);
    chk("wrap_unf", 32'(underflow), 32'd0);

    // Full: simultaneous write+read reuses the freed slot
    for (int i = 0; i < 16; i++) begin
      write      = 1'b1;
      write_data = 16'(16'h100 + i);
      step();
    end
    chk("sfull_pre", 32'(level), 32'd16);
    write_data = 16'h01AA;
    read       = 1'b1;
    step();
    write = 1'b0;
    read  = 1'b0;
    chk("sfull_level", 32'(level), 32'd16);
    chk("sfull_ovf",   32'(overflow), 32'd0);
    chk("sfull_head",  32'(read_data), 32'h101);
    for (int i = 1; i <= 16; i++) begin
      chk("sfull_drain", 32'(read_data), (i == 16) ? 32'h1AA : 32'(32'h100 + i));
      read = 1'b1;
      step();
    end
    read = 1'b0;
    chk("sfull_empty", 32'(empty), 32'd1);

    // Empty: simultaneous write+read -> write taken, underflow flagged
    write      = 1'b1;
    read       = 1'b1;
    write_data = 16'h02BB;
    step();
    write = 1'b0;
    read  = 1'b0;
    chk("sempty_unf",   32'(underflow), 32'd1);
    chk("sempty_level", 32'(level), 32'd1);
    chk("sempty_data",  32'(read_data), 32'h2BB);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_idle_reset("flush2");

    // Flush with write at level=5, overflow=1
    for (int i = 0; i < 17; i++) begin
      write      = 1'b1;
      write_data = 16'(16'h400 + i);
      step();
    end
    write = 1'b0;
    for (int i = 0; i < 11; i++) begin
      read = 1'b1;
      step();
    end
    read = 1'b0;
    chk("fl_pre_level", 32'(level), 32'd5);
    chk("fl_pre_ovf",   32'(overflow), 32'd1);
    chk("fl_pre_head",  32'(read_data), 32'h40B);
    flush      = 1'b1;
    write      = 1'b1;
    write_data = 16'h0555;
    step();
    flush = 1'b0;
    write = 1'b0;
    chk_idle_reset("flush3");
    step();
    chk("fl_post_level", 32'(level), 32'd0);

    // Async reset between edges at level=7
    for (int i = 0; i < 7; i++) begin
      write      = 1'b1;
      write_data = 16'(16'h600 + i);
      step();
    end
    write = 1'b0;
    chk("ar_pre_level", 32'(level), 32'd7);
    chk("ar_pre_head",  32'(read_data), 32'h600);
    #2;
    resetn = 1'b0;
    #1;
    chk_idle_reset("async_rst");
    step();
    resetn = 1'b1;
    step();
    chk_idle_reset("async_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
